// File: rtl/io_port_bank_if.sv
// Data-bus slice seen by io_port_bank: core-side address/store signals
// and the peripheral's combinational hit/read-data response.
interface io_port_bank_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        hit;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input hit, input rdata);
  modport slave  (input addr, input wdata, input we, output hit, output rdata);
endinterface

// File: rtl/io_port_bank.sv
// Multi-channel memory-mapped parallel I/O: synchronised inputs, output registers,
// and (with IO_EDGE_IRQ_EN defined) sticky change detection with a maskable irq.
module io_port_bank #(
  parameter int          WIDTH  = 8,
  parameter int          NPORTS = 4,
  parameter logic [31:0] BASE   = 32'h0000_0800
) (
  input  logic                     clk,
  input  logic                     reset1,
  io_port_bank_if.slave            bus,
  input  logic [NPORTS*WIDTH-1:0]  in_pins,
  output logic [NPORTS*WIDTH-1:0]  out_pins,
  output logic                     irq
);
  localparam int          NW   = NPORTS * WIDTH;
  localparam logic [31:0] SPAN = 32'(16 * NPORTS);
  localparam logic [31:0] TOP  = BASE + SPAN;

  logic [31:0]   off_s;
  logic [31:0]   ch_s;
  logic [1:0]    reg_s;
  logic          hit_s;
  logic          wr_s;
  logic          unused_s;
  logic [31:0]   rdata_s;
  logic [31:0]   word_s;
  logic [NW-1:0] s1_r;
  logic [NW-1:0] s2_r;
  logic [NW-1:0] data_out_r;

  // BASE is aligned to the window size, so the offset's low bits equal addr's.
  assign off_s    = bus.addr - BASE;
  assign ch_s     = {4'd0, off_s[31:4]};
  assign reg_s    = off_s[3:2];
  assign hit_s    = (bus.addr >= BASE) && (bus.addr < TOP);
  assign wr_s     = bus.we & hit_s;
  assign unused_s = ^{off_s[1:0], bus.wdata};

  // Two-stage input synchroniser and DATA_OUT registers
  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      s1_r       <= {NW{1'b0}};
      s2_r       <= {NW{1'b0}};
      data_out_r <= {NW{1'b0}};
    end else begin
      s1_r <= in_pins;
      s2_r <= s1_r;
      for (int c = 0; c < NPORTS; c++) begin
        if (wr_s && (ch_s == 32'(c)) && (reg_s == 2'd1)) begin
          data_out_r[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
        end
      end
    end
  end

  assign out_pins = data_out_r;

`ifdef IO_EDGE_IRQ_EN
  logic [NW-1:0] s3_r;
  logic [NW-1:0] edge_r;
  logic [NW-1:0] irq_en_r;
  logic [NW-1:0] clr_s;

  // W1C clear mask for the addressed channel's EDGE register
  always_comb begin
    clr_s = {NW{1'b0}};
    for (int c = 0; c < NPORTS; c++) begin
      if (wr_s && (ch_s == 32'(c)) && (reg_s == 2'd2)) begin
        clr_s[c*WIDTH +: WIDTH] = bus.wdata[WIDTH-1:0];
      end else begin
        clr_s[c*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end

  // Third sync stage, sticky EDGE (a same-cycle set beats the clear), IRQ_EN
  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      s3_r     <= {NW{1'b0}};
      edge_r   <= {NW{1'b0}};
      irq_en_r <= {NW{1'b0}};
    end else begin
      s3_r   <= s2_r;
      edge_r <= (edge_r & ~clr_s) | (s2_r ^ s3_r);
      for (int c = 0; c < NPORTS; c++) begin
        if (wr_s && (ch_s == 32'(c)) && (reg_s == 2'd3)) begin
          irq_en_r[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
        end
      end
    end
  end

  assign irq = |(edge_r & irq_en_r);
`else
  assign irq = 1'b0;
`endif

  // Side-effect-free read mux; only the addressed channel contributes
  always_comb begin
    rdata_s = 32'd0;
    word_s  = 32'd0;
    for (int c = 0; c < NPORTS; c++) begin
      case (reg_s)
        2'd0:    word_s = 32'(s2_r[c*WIDTH +: WIDTH]);
        2'd1:    word_s = 32'(data_out_r[c*WIDTH +: WIDTH]);
`ifdef IO_EDGE_IRQ_EN
        2'd2:    word_s = 32'(edge_r[c*WIDTH +: WIDTH]);
        2'd3:    word_s = 32'(irq_en_r[c*WIDTH +: WIDTH]);
`endif
        default: word_s = 32'd0;
      endcase
      rdata_s = rdata_s | ((hit_s && (ch_s == 32'(c))) ? word_s : 32'd0);
    end
  end

  assign bus.hit   = hit_s;
  assign bus.rdata = rdata_s;
endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (WIDTH=8, NPORTS=4, BASE=0x800).
module tb_io_port_bank;
  localparam logic [31:0] BASE = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        reset1 = 1'b0;
  logic [31:0] in_pins = 32'hFFFF_FFFF;
  logic [31:0] out_pins;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;

  io_port_bank_if bus();

  io_port_bank #(.WIDTH(8), .NPORTS(4), .BASE(BASE)) dut (
    .clk(clk), .reset1(reset1), .bus(bus),
    .in_pins(in_pins), .out_pins(out_pins), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus.addr = a;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (out_pins !== 32'h0) begin n_fail++; $display("FAIL reset_out_pins: got %h exp %h", out_pins, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    bus_read(BASE + 32'h4);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dataout_read: got %h exp %h", bus.rdata, 32'h0); end
    reset1 = 1'b1;
    tick();
    bus_read(BASE);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL sync_stage1: got %h exp %h", bus.rdata, 32'h0); end
    tick();
    bus_read(BASE);
    n_checks++; if (bus.rdata !== 32'hFF) begin n_fail++; $display("FAIL sync_datain: got %h exp %h", bus.rdata, 32'hFF); end
`ifdef IO_EDGE_IRQ_EN
    tick();
    bus_read(BASE + 32'h8);
    n_checks++; if (bus.rdata !== 32'hFF) begin n_fail++; $display("FAIL fill_edge: got %h exp %h", bus.rdata, 32'hFF); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fill_irq_masked: got %b exp 0", irq); end
    for (int c = 0; c < 4; c++) bus_write(BASE + 32'h8 + 32'(16 * c), 32'hFF);
    bus_read(BASE + 32'h38);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL edge_w1c_all: got %h exp %h", bus.rdata, 32'h0); end
`endif
  endtask

  task automatic test_output_write();
    bus_write(BASE + 32'h14, 32'h1A5);
    n_checks++; if (out_pins !== 32'h0000A500) begin n_fail++; $display("FAIL out_ch1: got %h exp %h", out_pins, 32'h0000A500); end
    bus_read(BASE + 32'h14);
    n_checks++; if (bus.rdata !== 32'h000000A5) begin n_fail++; $display("FAIL out_ch1_read: got %h exp %h", bus.rdata, 32'hA5); end
    bus_write(BASE + 32'h34, 32'hFFFF_FF5A);
    bus_write(BASE + 32'h04, 32'h0000_0011);
    n_checks++; if (out_pins !== 32'h5A00A511) begin n_fail++; $display("FAIL back_to_back: got %h exp %h", out_pins, 32'h5A00A511); end
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'h10);
    n_checks++; if (bus.rdata !== 32'hFF) begin n_fail++; $display("FAIL datain_ro: got %h exp %h", bus.rdata, 32'hFF); end
    n_checks++; if (out_pins !== 32'h5A00A511) begin n_fail++; $display("FAIL datain_write_side: got %h exp %h", out_pins, 32'h5A00A511); end
  endtask

  task automatic test_decode();
    bus_read(BASE + 32'h40);
    n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL hit_above: got %b exp 0", bus.hit); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_above: got %h exp %h", bus.rdata, 32'h0); end
    bus_read(BASE - 32'h4);
    n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL hit_below: got %b exp 0", bus.hit); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_below: got %h exp %h", bus.rdata, 32'h0); end
    bus_read(BASE + 32'h3C);
    n_checks++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL hit_top_word: got %b exp 1", bus.hit); end
    bus_read(BASE + 32'h36);
    n_checks++; if (bus.rdata !== 32'h5A) begin n_fail++; $display("FAIL byte_offset_ignored: got %h exp %h", bus.rdata, 32'h5A); end
    bus_write(BASE + 32'h44, 32'hFF);
    bus_write(BASE - 32'hC, 32'hFF);
    bus_write(BASE - 32'h3C, 32'hFF);
    n_checks++; if (out_pins !== 32'h5A00A511) begin n_fail++; $display("FAIL miss_write: got %h exp %h", out_pins, 32'h5A00A511); end
  endtask

`ifdef IO_EDGE_IRQ_EN
  task automatic test_edge_irq();
    bus_write(BASE + 32'h2C, 32'h01);
    in_pins[16] = 1'b0;
    tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_k: got %b exp 0", irq); end
    tick();
    bus_read(BASE + 32'h20);
    n_checks++; if (bus.rdata !== 32'hFE) begin n_fail++; $display("FAIL datain_k1: got %h exp %h", bus.rdata, 32'hFE); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_k1: got %b exp 0", irq); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_k2: got %b exp 1", irq); end
    bus_read(BASE + 32'h28);
    n_checks++; if (bus.rdata !== 32'h01) begin n_fail++; $display("FAIL edge_ch2: got %h exp %h", bus.rdata, 32'h01); end
    bus_write(BASE + 32'h28, 32'h01);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b exp 0", irq); end
    bus_read(BASE + 32'h28);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL edge_ch2_cleared: got %h exp %h", bus.rdata, 32'h0); end
  endtask

  task automatic test_collision();
    bus_write(BASE + 32'hC, 32'h01);
    in_pins[0] = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_first_irq: got %b exp 1", irq); end
    in_pins[0] = 1'b1;
    tick(); tick();
    bus_write(BASE + 32'h8, 32'h01);
    bus_read(BASE + 32'h8);
    n_checks++; if (bus.rdata !== 32'h01) begin n_fail++; $display("FAIL coll_set_wins: got %h exp %h", bus.rdata, 32'h01); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq: got %b exp 1", irq); end
    tick();
    bus_read(BASE + 32'h8);
    n_checks++; if (bus.rdata !== 32'h01) begin n_fail++; $display("FAIL coll_sticky: got %h exp %h", bus.rdata, 32'h01); end
    bus_write(BASE + 32'h8, 32'h01);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_final_clear: got %b exp 0", irq); end
  endtask
`else
  task automatic test_no_edge();
    in_pins[0] = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL noedge_irq: got %b exp 0", irq); end
    bus_read(BASE + 32'h8);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL noedge_edge_read: got %h exp %h", bus.rdata, 32'h0); end
    bus_write(BASE + 32'hC, 32'hFF);
    bus_read(BASE + 32'hC);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL noedge_irqen_read: got %h exp %h", bus.rdata, 32'h0); end
    bus_read(BASE);
    n_checks++; if (bus.rdata !== 32'hFE) begin n_fail++; $display("FAIL noedge_datain: got %h exp %h", bus.rdata, 32'hFE); end
    in_pins[0] = 1'b1;
    tick(); tick();
  endtask
`endif

  task automatic test_async_reset();
    bus_write(BASE + 32'h4, 32'h3C);
    n_checks++; if (out_pins !== 32'h5A00A53C) begin n_fail++; $display("FAIL pre_reset_out: got %h exp %h", out_pins, 32'h5A00A53C); end
    #1;
    reset1 = 1'b0;
    #1;
    n_checks++; if (out_pins !== 32'h0) begin n_fail++; $display("FAIL async_clear_out: got %h exp %h", out_pins, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_clear_irq: got %b exp 0", irq); end
    bus_read(BASE + 32'h4);
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL async_dataout_read: got %h exp %h", bus.rdata, 32'h0); end
    tick();
    reset1 = 1'b1;
    tick();
  endtask

  initial begin
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.we = 1'b0;
    test_reset();
    test_output_write();
    test_decode();
`ifdef IO_EDGE_IRQ_EN
    test_edge_irq();
    test_collision();
`else
    test_no_edge();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
